// File: rtl/led_scan_controller_pkg.sv
// Shared mode codes, FSM state encoding and select-step helpers for the LED scan controller.
package led_scan_pkg;

  typedef enum logic [1:0] {
    MODE_MANUAL   = 2'b00,
    MODE_FWD      = 2'b01,
    MODE_REV      = 2'b10,
    MODE_PINGPONG = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MANUAL = 2'b01,
    SCAN   = 2'b10
  } state_t;

  function automatic logic [1:0] sel_up(input logic [1:0] sel);
    return sel + 2'd1;
  endfunction

  function automatic logic [1:0] sel_down(input logic [1:0] sel);
    return sel - 2'd1;
  endfunction

endpackage

// File: rtl/led_scan_controller_dwell_timer.sv
// Dwell counter: counts 0..DWELL_CYCLES-1 while running, flags the terminal count.
module dwell_timer #(
  parameter int unsigned DWELL_CYCLES = 4194303
) (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Clear,
  input  logic i_Run,
  output logic o_Tick
);

  localparam int unsigned CNT_W = $clog2(DWELL_CYCLES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Tick only on a cycle that actually counts; a clear cycle restarts the dwell.
  assign o_Tick = i_Run && !i_Clear && (count == LAST);

  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear || !i_Run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_scan_controller.sv
// LED scan controller: drives a 2-bit demux select in manual, forward, reverse or ping-pong order.
// Ping-pong (mode 11) is built only with LED_SCAN_PINGPONG_EN; otherwise mode 11 scans forward.
module led_scan_controller
  import led_scan_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4194303
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Enable,
  input  logic [1:0] i_Mode,
  input  logic [1:0] i_Manual_Sel,
  output logic [1:0] o_Sel,
  output logic       o_Step,
  output logic       o_Wrap
);

  state_t     state;
  state_t     state_next;
  mode_t      mode_in;
  mode_t      mode_q;
  logic       dwell_run;
  logic       dwell_clear;
  logic       dwell_tick;
  logic [1:0] step_sel;
  logic       step_wrap;
`ifdef LED_SCAN_PINGPONG_EN
  logic       dir_up;
  logic       dir_up_next;
`endif

  assign mode_in = mode_t'(i_Mode);

  always_comb begin
    state_next = SCAN;
    if (!i_Enable) begin
      state_next = IDLE;
    end else if (mode_in == MODE_MANUAL) begin
      state_next = MANUAL;
    end
  end

  // Dwell restarts on SCAN entry or any mode change, so each scan segment gets a full dwell.
  assign dwell_run   = (state_next == SCAN);
  assign dwell_clear = !dwell_run || (state != SCAN) || (mode_in != mode_q);

  dwell_timer #(
    .DWELL_CYCLES(DWELL_CYCLES)
  ) u_dwell_timer (
    .i_Clk   (i_Clk),
    .i_Reset (i_Reset),
    .i_Clear (dwell_clear),
    .i_Run   (dwell_run),
    .o_Tick  (dwell_tick)
  );

  always_comb begin
    step_sel  = sel_up(o_Sel);
    step_wrap = (o_Sel == 2'd3);
`ifdef LED_SCAN_PINGPONG_EN
    dir_up_next = dir_up;
`endif
    case (mode_in)
      MODE_REV: begin
        step_sel  = sel_down(o_Sel);
        step_wrap = (o_Sel == 2'd0);
      end
`ifdef LED_SCAN_PINGPONG_EN
      MODE_PINGPONG: begin
        step_wrap = 1'b0;
        if (dir_up) begin
          step_sel = sel_up(o_Sel);
          if (step_sel == 2'd3) begin
            dir_up_next = 1'b0;
            step_wrap   = 1'b1;
          end
        end else begin
          step_sel = sel_down(o_Sel);
          if (step_sel == 2'd0) begin
            dir_up_next = 1'b1;
            step_wrap   = 1'b1;
          end
        end
      end
`endif
      default: begin
        step_sel  = sel_up(o_Sel);
        step_wrap = (o_Sel == 2'd3);
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state  <= IDLE;
      mode_q <= MODE_MANUAL;
      o_Sel  <= '0;
      o_Step <= 1'b0;
      o_Wrap <= 1'b0;
`ifdef LED_SCAN_PINGPONG_EN
      dir_up <= 1'b1;
`endif
    end else begin
      state  <= state_next;
      mode_q <= mode_in;
      o_Step <= 1'b0;
      o_Wrap <= 1'b0;
      case (state_next)
        MANUAL: o_Sel <= i_Manual_Sel;
        SCAN: begin
          if (dwell_tick) begin
            o_Sel  <= step_sel;
            o_Step <= 1'b1;
            o_Wrap <= step_wrap;
`ifdef LED_SCAN_PINGPONG_EN
            dir_up <= dir_up_next;
`endif
          end
        end
        default: o_Sel <= o_Sel;
      endcase
    end
  end

endmodule
